// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and sizing constants for the sequential restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 4;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/addsub_n.sv
// addsub_n: N-bit ripple-carry adder/subtractor; mode=1 subtracts (b inverted, carry-in set).
module addsub_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0]   c;
    logic [N-1:0] bx;
    assign c[0] = mode;
    assign bx   = b ^ {N{mode}};
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: start/done unsigned restoring divider, one quotient bit per clock.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [WIDTH:0]   a, a_sh, a_new, t;
    logic [WIDTH-1:0] q, m, q_new;
    logic [WIDTH:0]   q_ext;
    logic [CW-1:0]    count;
    logic             no_borrow, neg, last;

    assign a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
    assign last  = count == CW'(1);

    addsub_n #(.N(WIDTH + 1)) u_sub (
        .a    (a_sh),
        .b    ({1'b0, m}),
        .mode (1'b1),
        .sum  (t),
        .cout (no_borrow)
    );

    // The sign bit and the borrow always agree because a_sh < 2*m here.
    assign neg   = t[WIDTH] & ~no_borrow;
    assign a_new = neg ? a_sh : t;
    assign q_ext = {q, ~neg};
    assign q_new = q_ext[WIDTH-1:0];

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? ((divisor == '0) ? DONE : CALC) : IDLE;
            CALC:    state_n = last ? DONE : CALC;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            a           <= '0;
            q           <= dividend;
            m           <= divisor;
            count       <= CW'(WIDTH);
            div_by_zero <= divisor == '0;
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == CALC) begin
            a     <= a_new;
            q     <= q_new;
            count <= count - 1'b1;
            if (last) begin
                quotient  <= q_new;
                remainder <= a_new[WIDTH-1:0];
            end
        end
    end
endmodule
